fifo_wptr_full: RTL and testbench

FIFO_WPTR_FULL -- requirements
Module: fifo_wptr_full

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/fifo_sync_ptr.sv | 35 +++
 rtl/fifo_wptr_full.sv | 91 +++++++++
 tb/tb_fifo_wptr_full.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO pointer helpers: Gray/binary conversion and the default address width.
// Used by both the write-side (fifo_wptr_full) and read-side (fifo_rptr_empty) pointer blocks.
package fifo_pkg;

  localparam int ADDRSIZE_DEFAULT = 4;
  localparam int PTR_MAX_W        = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_word_t;

  function automatic ptr_word_t bin2gray(input ptr_word_t bin);
    return (bin >> 1) ^ bin;
  endfunction

  // Prefix-XOR from the MSB down, built with log2 doubling shifts.
  function automatic ptr_word_t gray2bin(input ptr_word_t gray);
    ptr_word_t bin;
    bin = gray;
    for (int shift = 1; shift < PTR_MAX_W; shift = shift * 2) begin
      bin = bin ^ (bin >> shift);
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_sync_ptr.sv
// Multi-flop synchronizer for a Gray-coded pointer crossing into the clk domain.
// Generic in width and depth so it serves both the read-to-write and write-to-read directions.
module fifo_sync_ptr #(
  parameter int WIDTH       = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];

  always_comb begin
    sync_d[0] = d;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // NOTE: every stage is reset, not just the output; a stale pointer left in an
  // inner stage would surface as a bogus level a few cycles after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '{default: '0};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer and status logic of an async FIFO: Gray write pointer,
// full / almost-full / fill level against the synchronized read pointer, sticky overflow.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE    = ADDRSIZE_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   rptr,
  input  logic                wovf_clr,
  output logic                wen,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                awfull,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                woverflow
);

  localparam int PW = ADDRSIZE + 1;

  logic [PW-1:0] wq2_rptr;
  logic [PW-1:0] wbin_q,   wbin_d;
  logic [PW-1:0] wptr_q,   wptr_d;
  logic [PW-1:0] wlevel_q, wlevel_d;
  logic          wfull_q,  wfull_d;
  logic          awfull_q, awfull_d;
  logic          wovf_q,   wovf_d;
  logic [PW-1:0] wbin_ahead;
  logic [PW-1:0] wgray_ahead;
  logic [PW-1:0] full_tgt;
  logic [PW-1:0] rbin;

  fifo_sync_ptr #(
    .WIDTH       (PW),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_rptr (
    .clk   (wclk),
    .rst_n (wrst_n),
    .d     (rptr),
    .q     (wq2_rptr)
  );

  assign wen = winc & ~wfull_q;

  // NOTE: every signal gets a value on every path through this block, so no latches are inferred.
  always_comb begin
    wbin_d      = wbin_q + PW'(wen);
    wptr_d      = PW'(bin2gray(PTR_MAX_W'(wbin_d)));
    wbin_ahead  = wbin_d + PW'(1);
    wgray_ahead = PW'(bin2gray(PTR_MAX_W'(wbin_ahead)));
    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    full_tgt    = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
    rbin        = PW'(gray2bin(PTR_MAX_W'(wq2_rptr)));
    wfull_d     = (wptr_d == full_tgt);
    awfull_d    = (wgray_ahead == full_tgt);
    wlevel_d    = wbin_d - rbin;
    // A set on the same edge as a clear wins.
    wovf_d      = (winc & wfull_q) | (wovf_q & ~wovf_clr);
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wfull_q  <= 1'b0;
      awfull_q <= 1'b0;
      wlevel_q <= '0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wfull_q  <= wfull_d;
      awfull_q <= awfull_d;
      wlevel_q <= wlevel_d;
      wovf_q   <= wovf_d;
    end
  end

  assign waddr     = wbin_q[ADDRSIZE-1:0];
  assign wptr      = wptr_q;
  assign wfull     = wfull_q;
  assign awfull    = awfull_q;
  assign wlevel    = wlevel_q;
  assign woverflow = wovf_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Self-checking bench for fifo_wptr_full (ADDRSIZE=4, SYNC_STAGES=2) against a
// counting model: total writes accepted, total reads, read count seen two edges late.
module tb_fifo_wptr_full;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          wclk = 1'b0;
  logic          wrst_n;
  logic          winc;
  logic [AW:0]   rptr;
  logic          wovf_clr;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [AW:0]   wptr;
  logic          wfull;
  logic          awfull;
  logic [AW:0]   wlevel;
  logic          woverflow;

  fifo_wptr_full #(.ADDRSIZE(AW), .SYNC_STAGES(2)) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .winc      (winc),
    .rptr      (rptr),
    .wovf_clr  (wovf_clr),
    .wen       (wen),
    .waddr     (waddr),
    .wptr      (wptr),
    .wfull     (wfull),
    .awfull    (awfull),
    .wlevel    (wlevel),
    .woverflow (woverflow)
  );

  always #5 wclk = ~wclk;

  int errors = 0;
  int checks = 0;

  // Model state: counts of accepted writes and issued reads, plus the read count
  // as the write side sees it after the two-flop crossing.
  int m_w, m_r, m_h0, m_h1, m_level;
  bit m_full, m_afull, m_ovf;
  bit exp_wen, obs_wen;
  logic [AW-1:0] obs_waddr_pre;

  function automatic logic [AW:0] gray(input int n);
    int b;
    b = n % 32;
    return 5'(b ^ (b >> 1));
  endfunction

  task automatic model_reset();
    m_w = 0; m_r = 0; m_h0 = 0; m_h1 = 0; m_level = 0;
    m_full = 0; m_afull = 0; m_ovf = 0;
  endtask

  // One write-clock cycle: drive inputs, sample pre-edge wen/waddr, advance the model, settle.
  task automatic tick(input bit inc, input bit clr);
    int rd_seen;
    winc = inc; wovf_clr = clr; rptr = gray(m_r);
    #1;
    obs_wen = wen; obs_waddr_pre = waddr; exp_wen = inc && !m_full;
    @(posedge wclk);
    rd_seen = m_h1; m_h1 = m_h0; m_h0 = m_r;
    if (exp_wen) m_w++;
    m_ovf   = (inc && m_full) || (m_ovf && !clr);
    m_level = m_w - rd_seen;
    m_full  = (m_level == DEPTH);
    m_afull = (m_level == DEPTH - 1);
    #1;
  endtask

  task automatic do_reset();
    winc = 0; wovf_clr = 0; rptr = '0;
    wrst_n = 1'b0;
    #2;
    wrst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    winc = 0; wovf_clr = 0; rptr = '0; wrst_n = 1'b0;
    model_reset();
    #12;
    checks++;
    if ({wen, waddr, wptr, wfull, awfull, wlevel, woverflow} !== '0)
      $display("FAIL reset_outputs: got %0h expected 0", {wen, waddr, wptr, wfull, awfull, wlevel, woverflow});
    @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH; i++) begin
      tick(1, 0);
      checks++;
      if (obs_wen !== 1'b1) begin errors++; $display("FAIL fill_wen[%0d]: got %b expected 1", i, obs_wen); end
      checks++;
      if (wptr !== gray(m_w) || waddr !== 4'(m_w % DEPTH))
        begin errors++; $display("FAIL fill_ptr[%0d]: wptr=%b waddr=%0d expected wptr=%b waddr=%0d", i, wptr, waddr, gray(m_w), m_w % DEPTH); end
      checks++;
      if (wfull !== m_full || awfull !== m_afull || wlevel !== 5'(m_level))
        begin errors++; $display("FAIL fill_status[%0d]: full=%b afull=%b level=%0d expected %b %b %0d", i, wfull, awfull, wlevel, m_full, m_afull, m_level); end
      if (i == DEPTH - 1) begin
        checks++;
        if (awfull !== 1'b1) begin errors++; $display("FAIL fill_awfull_at_15: got %b expected 1", awfull); end
      end
    end
    checks++;
    if (wfull !== 1'b1 || wlevel !== 5'd16 || wptr !== 5'b11000)
      begin errors++; $display("FAIL fill_final: full=%b level=%0d wptr=%b expected 1 16 11000", wfull, wlevel, wptr); end
  endtask

  task automatic test_overflow();
    tick(1, 0);
    checks++;
    if (obs_wen !== 1'b0 || wptr !== 5'b11000 || waddr !== 4'd0 || woverflow !== 1'b1)
      begin errors++; $display("FAIL ovf_set: wen=%b wptr=%b waddr=%0d ovf=%b expected 0 11000 0 1", obs_wen, wptr, waddr, woverflow); end
    tick(0, 0);
    checks++;
    if (woverflow !== 1'b1) begin errors++; $display("FAIL ovf_hold: got %b expected 1", woverflow); end
    tick(0, 1);
    checks++;
    if (woverflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", woverflow); end
    tick(1, 1);
    checks++;
    if (woverflow !== 1'b1 || wptr !== 5'b11000)
      begin errors++; $display("FAIL ovf_set_wins: ovf=%b wptr=%b expected 1 11000", woverflow, wptr); end
  endtask

  task automatic test_drain();
    m_r = 1;
    for (int e = 1; e <= 3; e++) begin
      tick(0, 0);
      checks++;
      if (wfull !== m_full || wlevel !== 5'(m_level))
        begin errors++; $display("FAIL drain_edge[%0d]: full=%b level=%0d expected %b %0d", e, wfull, wlevel, m_full, m_level); end
    end
    checks++;
    if (wfull !== 1'b0 || wlevel !== 5'd15)
      begin errors++; $display("FAIL drain_final: full=%b level=%0d expected 0 15", wfull, wlevel); end
    tick(1, 0);
    checks++;
    if (obs_wen !== 1'b1 || obs_waddr_pre !== 4'd0 || waddr !== 4'd1 || wfull !== 1'b1)
      begin errors++; $display("FAIL drain_next_write: wen=%b addr=%0d next=%0d full=%b expected 1 0 1 1", obs_wen, obs_waddr_pre, waddr, wfull); end
  endtask

  task automatic test_wrap();
    logic [AW:0] prev;
    do_reset();
    prev = wptr;
    for (int i = 0; i < 40; i++) begin
      m_r = (i >= 4) ? i - 4 : 0;
      tick(1, 0);
      checks++;
      if (obs_waddr_pre !== 4'(i % DEPTH) || wfull !== 1'b0 || obs_wen !== 1'b1)
        begin errors++; $display("FAIL wrap_addr[%0d]: addr=%0d full=%b wen=%b expected %0d 0 1", i, obs_waddr_pre, wfull, obs_wen, i % DEPTH); end
      checks++;
      if ($countones(wptr ^ prev) != 1 || wptr !== gray(i + 1))
        begin errors++; $display("FAIL wrap_gray[%0d]: prev=%b now=%b expected %b", i, prev, wptr, gray(i + 1)); end
      prev = wptr;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 10; i++) tick(1, 0);
    checks++;
    if (waddr !== 4'd10) begin errors++; $display("FAIL areset_pre: waddr=%0d expected 10", waddr); end
    winc = 0;
    #3;
    wrst_n = 1'b0;
    #1;
    checks++;
    if ({wen, waddr, wptr, wfull, awfull, wlevel, woverflow} !== '0)
      begin errors++; $display("FAIL areset_outputs: got %0h expected 0", {wen, waddr, wptr, wfull, awfull, wlevel, woverflow}); end
    #1;
    wrst_n = 1'b1;
    model_reset();
    tick(1, 0);
    checks++;
    if (obs_wen !== 1'b1 || obs_waddr_pre !== 4'd0 || waddr !== 4'd1)
      begin errors++; $display("FAIL areset_first_write: wen=%b addr=%0d next=%0d expected 1 0 1", obs_wen, obs_waddr_pre, waddr); end
  endtask

  task automatic test_random();
    bit inc, clr;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      inc = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 7) == 0);
      if (m_r < m_w && $urandom_range(0, 2) == 0) m_r++;
      tick(inc, clr);
      checks++;
      if (obs_wen !== exp_wen) begin errors++; $display("FAIL rand_wen[%0d]: got %b expected %b", c, obs_wen, exp_wen); end
      checks++;
      if (wptr !== gray(m_w) || waddr !== 4'(m_w % DEPTH))
        begin errors++; $display("FAIL rand_ptr[%0d]: wptr=%b waddr=%0d expected %b %0d", c, wptr, waddr, gray(m_w), m_w % DEPTH); end
      checks++;
      if (wfull !== m_full || awfull !== m_afull || wlevel !== 5'(m_level) || woverflow !== m_ovf)
        begin errors++; $display("FAIL rand_status[%0d]: full=%b afull=%b level=%0d ovf=%b expected %b %b %0d %b", c, wfull, awfull, wlevel, woverflow, m_full, m_afull, m_level, m_ovf); end
    end
  endtask

  initial begin
    test_reset();
    @(posedge wclk); #1;
    test_fill();
    test_overflow();
    test_drain();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
